contador_mod: RTL and testbench
===============================

# contador_mod

Parametrised, segmented-adder modulo counter. Replaces the fixed 24-bit free-running counter with configurable width, a programmable step, up/down direction, a programmable terminal value and parallel load. It reports wrap events as a one-cycle terminal-count pulse and as a sticky overflow flag. It sits in the timing and sequencing paths as the general-purpose tick, divider and event counter.

## Interface
- WIDTH, 24, counter width in bits; must be a multiple of SEG.
- SEG, 12, width of each internal adder slice. Slices are chained by ripple carry: slice k's carry-out feeds slice k+1's carry-in.
- STEP_W, 8, width of the step input.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  count enable.
- up  in  1  direction: 1 counts up, 0 counts down.
- step  in  STEP_W  increment/decrement amount; zero-extended to WIDTH.
- limit  in  WIDTH  terminal value; the count range is 0..limit.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value loaded by load.
- clear_ovf  in  1  clears the sticky overflow flag.
- count  out  WIDTH  registered count.
- tc  out  1  registered terminal-count pulse, high for one cycle per wrap.
- ovf  out  1  registered sticky wrap flag.

## Operation
- Priority per rising edge, highest first: rst_n low, then load, then en, then hold.
- Reset (rst_n=0): count=0, tc=0, ovf=0.
- Load: count=load_val, stored unmodified even if load_val > limit. tc=0; ovf is unchanged except by clear_ovf.
- Count, up=1: sum = count + step, computed at WIDTH+1 bits through the slice chain.
  - If sum > limit (this includes a carry out of the top slice): count=0 and tc=1.
  - Otherwise count=sum and tc=0.
- Count, up=0:
  - If step > count: count=limit and tc=1.
  - Otherwise count = count − step and tc=0.
- step=0 with en=1: count holds and tc=0, for any count and limit.
- Wrap discards the remainder; there is no modulo carry-over.
- With en=0 and load=0: count holds and tc=0.
- ovf next-state: set to 1 in any cycle where tc becomes 1. If set and clear_ovf coincide, set wins. Otherwise clear_ovf=1 gives ovf=0, and clear_ovf=0 holds ovf.
- clear_ovf acts regardless of en and load; rst_n still overrides it.
- limit and step are sampled every cycle; changing them takes effect on the next edge, with no resynchronisation.
- limit = all ones with step=1 gives a plain 2^WIDTH free-running counter.
- The adder is combinational within one cycle. The SEG split is structural only and is not visible at the ports.

## Timing
- Latency: a control input sampled at edge N is reflected on count, tc and ovf immediately after edge N.
- tc is high in exactly the cycle in which count shows the wrapped value (0 when counting up, limit when counting down).
- Back-to-back wraps (for example limit=0, up, step=1) give tc high on every enabled cycle.
- rst_n deasserting: the first count update happens on the first edge sampled with rst_n=1.
- Reset mid-count overrides load, en and clear_ovf on that edge.

## Test plan
- Reset/basic up: rst_n=0 for 2 cycles, then en=1, up=1, step=1, limit=9.
  - Expect count 0 after reset, then 1,2,…,9,0; tc=1 only with the 0, ovf=1 from then on.
- Step and wrap: limit=10, step=3, up=1, start from 0.
  - Expect count 3,6,9,0 with tc on the 0; sum 12 is discarded, not carried over.
- Down count: load_val=2 with load=1, then up=0, step=1, limit=5.
  - Expect 2,1,0,5,4 with tc only on the 5.
- Segment carry and full-width wrap: WIDTH=24, SEG=12, limit=0xFFFFFF, step=1.
  - From load 0x000FFF expect 0x001000.
  - From load 0xFFFFFE expect 0xFFFFFF, then 0x000000 with tc=1.
- Priority and sticky flag:
  - load=1 with en=1: load_val wins and tc=0.
  - clear_ovf=1 in the same cycle as a wrap: ovf stays 1.
  - clear_ovf=1 with no wrap: ovf goes to 0 next cycle.
- Reset mid-operation: pulse rst_n=0 for 1 cycle with count=7, ovf=1, load=1.
  - Expect count=0, tc=0, ovf=0 after that edge; counting resumes from 0.

Source files
------------

// File: rtl/contador_mod.sv
// Parametrised modulo counter. Supports a programmable step, up/down direction,
// a terminal value and parallel load. The adder is built as a ripple-carry chain of SEG-bit slices.
module contador_mod #(
  parameter int WIDTH  = 24,
  parameter int SEG    = 12,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clear_ovf,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf
);

  localparam int NSEG = WIDTH / SEG;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_step_ext;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry [0:NSEG];
  logic             w_up_wrap;
  logic             w_dn_wrap;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_tc;
  logic             w_next_ovf;

  assign w_step_ext = WIDTH'(step);

  // Counting down reuses the same chain as count + ~step + 1; a carry out of
  // the top slice then means "no borrow", i.e. step <= count.
  assign w_opb      = up ? w_step_ext : ~w_step_ext;
  assign w_carry[0] = ~up;

  for (genvar k = 0; k < NSEG; k++) begin : g_slice
    assign {w_carry[k+1], w_sum[k*SEG +: SEG]} =
        {1'b0, r_count[k*SEG +: SEG]} + {1'b0, w_opb[k*SEG +: SEG]}
        + {{SEG{1'b0}}, w_carry[k]};
  end

  assign w_up_wrap = w_carry[NSEG] | (w_sum > limit);
  assign w_dn_wrap = ~w_carry[NSEG];

  always_comb begin
    w_next_count = r_count;
    w_next_tc    = 1'b0;
    if (load) begin
      w_next_count = load_val;
    end else if (en && (step != '0)) begin
      if (up) begin
        if (w_up_wrap) begin
          w_next_count = '0;
          w_next_tc    = 1'b1;
        end else begin
          w_next_count = w_sum;
        end
      end else begin
        if (w_dn_wrap) begin
          w_next_count = limit;
          w_next_tc    = 1'b1;
        end else begin
          w_next_count = w_sum;
        end
      end
    end
  end

  // A wrap in the same cycle as clear_ovf keeps the flag set.
  assign w_next_ovf = w_next_tc | (r_ovf & ~clear_ovf);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_tc    <= w_next_tc;
      r_ovf   <= w_next_ovf;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_contador_mod.sv
// Directed testbench for contador_mod. It uses the default 24-bit / 12-bit slice configuration,
// and every expected value is written out by hand.
module tb_contador_mod;

  localparam int WIDTH  = 24;
  localparam int SEG    = 12;
  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              up;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              clear_ovf;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              ovf;

  int n_vec = 0;
  int n_err = 0;

  contador_mod #(.WIDTH(WIDTH), .SEG(SEG), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .step(step), .limit(limit),
    .load(load), .load_val(load_val), .clear_ovf(clear_ovf),
    .count(count), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it before looking at outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1; step = 8'd0; limit = 24'd0;
    load = 1'b0; load_val = 24'd0; clear_ovf = 1'b0;
    tick(); tick();
    n_vec++; if (count !== 24'd0) begin n_err++; $display("FAIL reset_count got %0h want 0", count); end
    n_vec++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc got %b want 0", tc); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
  endtask

  task automatic test_basic_up();
    logic [WIDTH-1:0] exp_c [10];
    exp_c = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8, 24'd9, 24'd0};
    rst_n = 1'b1; en = 1'b1; up = 1'b1; step = 8'd1; limit = 24'd9;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++; if (count !== exp_c[i]) begin n_err++; $display("FAIL up_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      n_vec++; if (tc !== (i == 9)) begin n_err++; $display("FAIL up_tc[%0d] got %b want %b", i, tc, (i == 9)); end
      n_vec++; if (ovf !== (i == 9)) begin n_err++; $display("FAIL up_ovf[%0d] got %b want %b", i, ovf, (i == 9)); end
    end
    en = 1'b0;
    tick();
    n_vec++; if (count !== 24'd0 || tc !== 1'b0 || ovf !== 1'b1) begin
      n_err++; $display("FAIL hold count=%0d tc=%b ovf=%b want 0 0 1", count, tc, ovf); end
  endtask

  task automatic test_step_wrap();
    logic [WIDTH-1:0] exp_c [4];
    exp_c = '{24'd3, 24'd6, 24'd9, 24'd0};
    load = 1'b1; load_val = 24'd0; en = 1'b0;
    tick();
    load = 1'b0;
    n_vec++; if (count !== 24'd0 || tc !== 1'b0 || ovf !== 1'b1) begin
      n_err++; $display("FAIL load0 count=%0d tc=%b ovf=%b want 0 0 1", count, tc, ovf); end
    limit = 24'd10; step = 8'd3; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (count !== exp_c[i]) begin n_err++; $display("FAIL step3_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      n_vec++; if (tc !== (i == 3)) begin n_err++; $display("FAIL step3_tc[%0d] got %b want %b", i, tc, (i == 3)); end
    end
  endtask

  task automatic test_down();
    logic [WIDTH-1:0] exp_c [4];
    exp_c = '{24'd1, 24'd0, 24'd5, 24'd4};
    en = 1'b0; load = 1'b1; load_val = 24'd2;
    tick();
    load = 1'b0;
    n_vec++; if (count !== 24'd2) begin n_err++; $display("FAIL dn_load got %0d want 2", count); end
    up = 1'b0; step = 8'd1; limit = 24'd5; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (count !== exp_c[i]) begin n_err++; $display("FAIL dn_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      n_vec++; if (tc !== (i == 2)) begin n_err++; $display("FAIL dn_tc[%0d] got %b want %b", i, tc, (i == 2)); end
    end
    step = 8'd3;
    tick();
    n_vec++; if (count !== 24'd1 || tc !== 1'b0) begin n_err++; $display("FAIL dn_step3 count=%0d tc=%b want 1 0", count, tc); end
    tick();
    n_vec++; if (count !== 24'd5 || tc !== 1'b1) begin n_err++; $display("FAIL dn_borrow count=%0d tc=%b want 5 1", count, tc); end
  endtask

  task automatic test_segment_carry();
    up = 1'b1; step = 8'd1; limit = 24'hFFFFFF;
    en = 1'b0; load = 1'b1; load_val = 24'h000FFF;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    n_vec++; if (count !== 24'h001000 || tc !== 1'b0) begin n_err++; $display("FAIL seg_carry count=%06h tc=%b want 001000 0", count, tc); end
    en = 1'b0; load = 1'b1; load_val = 24'hFFFFFE;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    n_vec++; if (count !== 24'hFFFFFF || tc !== 1'b0) begin n_err++; $display("FAIL full_pre count=%06h tc=%b want ffffff 0", count, tc); end
    tick();
    n_vec++; if (count !== 24'h000000 || tc !== 1'b1) begin n_err++; $display("FAIL full_wrap count=%06h tc=%b want 000000 1", count, tc); end
    en = 1'b0; load = 1'b1; load_val = 24'hFFFFF0;
    tick();
    load = 1'b0; en = 1'b1; step = 8'h20;
    tick();
    n_vec++; if (count !== 24'h000000 || tc !== 1'b1) begin n_err++; $display("FAIL top_cout count=%06h tc=%b want 000000 1", count, tc); end
  endtask

  task automatic test_priority();
    limit = 24'd9; step = 8'd1; up = 1'b1;
    en = 1'b1; load = 1'b1; load_val = 24'h55;
    tick();
    load = 1'b0;
    n_vec++; if (count !== 24'h55 || tc !== 1'b0) begin n_err++; $display("FAIL load_wins count=%0h tc=%b want 55 0", count, tc); end
    tick();
    n_vec++; if (count !== 24'd0 || tc !== 1'b1) begin n_err++; $display("FAIL above_limit count=%0h tc=%b want 0 1", count, tc); end
    en = 1'b0; load = 1'b1; load_val = 24'd9;
    tick();
    load = 1'b0; en = 1'b1; clear_ovf = 1'b1;
    tick();
    n_vec++; if (count !== 24'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
      n_err++; $display("FAIL set_wins count=%0d tc=%b ovf=%b want 0 1 1", count, tc, ovf); end
    en = 1'b0;
    tick();
    clear_ovf = 1'b0;
    n_vec++; if (ovf !== 1'b0 || tc !== 1'b0) begin n_err++; $display("FAIL clear_ovf ovf=%b tc=%b want 0 0", ovf, tc); end
    tick();
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_stays_clear got %b want 0", ovf); end
  endtask

  task automatic test_step_zero();
    limit = 24'd3; en = 1'b0; load = 1'b1; load_val = 24'h10;
    tick();
    load = 1'b0; en = 1'b1; step = 8'd0; up = 1'b1;
    tick();
    n_vec++; if (count !== 24'h10 || tc !== 1'b0) begin n_err++; $display("FAIL step0_up count=%0h tc=%b want 10 0", count, tc); end
    up = 1'b0;
    tick();
    n_vec++; if (count !== 24'h10 || tc !== 1'b0) begin n_err++; $display("FAIL step0_dn count=%0h tc=%b want 10 0", count, tc); end
  endtask

  task automatic test_back_to_back();
    en = 1'b0; load = 1'b1; load_val = 24'd0; limit = 24'd0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; step = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (count !== 24'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
        n_err++; $display("FAIL b2b[%0d] count=%0d tc=%b ovf=%b want 0 1 1", i, count, tc, ovf); end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b0; load = 1'b1; load_val = 24'd7; limit = 24'd9;
    tick();
    n_vec++; if (count !== 24'd7 || ovf !== 1'b1) begin n_err++; $display("FAIL pre_rst count=%0d ovf=%b want 7 1", count, ovf); end
    rst_n = 1'b0; load = 1'b1; load_val = 24'h33; en = 1'b1;
    tick();
    n_vec++; if (count !== 24'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL mid_rst count=%0h tc=%b ovf=%b want 0 0 0", count, tc, ovf); end
    rst_n = 1'b1; load = 1'b0; up = 1'b1; step = 8'd1;
    tick();
    n_vec++; if (count !== 24'd1 || tc !== 1'b0) begin n_err++; $display("FAIL resume count=%0d tc=%b want 1 0", count, tc); end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_step_wrap();
    test_down();
    test_segment_carry();
    test_priority();
    test_step_zero();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
